// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift_arbiter slice.
//   SH_DW / SH_SW           : operand and shift-amount widths of the shared shifter
//   SH_DIR_LEFT / _RIGHT    : encoding of the direction bit
//   state_t (ST_EMPTY/FULL) : response register state, also exported for debug
package shift_arbiter_pkg;

  localparam int SH_DW = 8;
  localparam int SH_SW = 3;

  localparam logic SH_DIR_LEFT  = 1'b0;
  localparam logic SH_DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 8-bit logical barrel shifter, zero fill.
//   data_in  : operand
//   shift    : shift amount 0..7
//   dir      : 0 = left, 1 = right
//   data_out : shifted result; shift 0 passes data_in unchanged
module barrel_shifter
  import shift_arbiter_pkg::*;
(
  input  logic [SH_DW-1:0] data_in,
  input  logic [SH_SW-1:0] shift,
  input  logic             dir,
  output logic [SH_DW-1:0] data_out
);

  logic [SH_DW-1:0] stage;

  // Log-depth structure: stage b shifts by 2^b when shift[b] is set.
  always_comb begin
    stage = data_in;
    for (int b = 0; b < SH_SW; b++) begin
      if (shift[b]) begin
        if (dir == SH_DIR_RIGHT) begin
          stage = stage >> (1 << b);
        end else begin
          stage = stage << (1 << b);
        end
      end
    end
    data_out = stage;
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel_shifter among NREQ requesters.
//   clk, rst_n   : clock, synchronous active-low reset
//   req_valid    : per-requester command present
//   req_ready    : per-requester accept (one-hot or zero)
//   req_data     : 8 bits per requester, requester i at [8i+7:8i]
//   req_shift    : 3 bits per requester, requester i at [3i+2:3i]
//   req_dir      : per-requester direction, 0 = left, 1 = right
//   rsp_valid    : result register holds a result
//   rsp_ready    : consumer takes the result
//   rsp_data     : registered shifted result
//   rsp_id       : index of the requester that produced rsp_data
//   dbg_state    : current response-register state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A requester keeps its command stable while valid && !ready;
// ready never depends on the same port's data. rsp_valid/rsp_data/rsp_id
// come straight from registers, so no req_* input reaches any rsp_* output.
//
// IDW must be wide enough to index NREQ requesters (2^IDW >= NREQ).
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [SH_DW*NREQ-1:0]   req_data,
  input  logic [SH_SW*NREQ-1:0]   req_shift,
  input  logic [NREQ-1:0]         req_dir,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [SH_DW-1:0]        rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output state_t                  dbg_state
);

  state_t           state_q;
  state_t           state_d;
  logic [IDW-1:0]   ptr_q;

  logic             free;
  logic             found;
  logic             accept;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]  rot;
  logic [IDW-1:0]   off;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   sel;
  logic [IDW-1:0]   ptr_nxt;

  logic [SH_DW-1:0] sh_in;
  logic [SH_SW-1:0] sh_amt;
  logic             sh_dir;
  logic [SH_DW-1:0] sh_out;

  // (a + b) mod NREQ for a, b < NREQ; one extra bit holds the carry.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                              input logic [IDW-1:0] b);
    logic [IDW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (IDW+1)'(NREQ)) begin
      s = s - (IDW+1)'(NREQ);
    end
    return s[IDW-1:0];
  endfunction

  // The register can take a new result when empty or when the current one
  // leaves on this same edge.
  assign free = (state_q == ST_EMPTY) || rsp_ready;

  // Rotate so that bit 0 of rot is requester ptr_q; the doubled copy makes
  // the wrap from NREQ-1 back to 0 fall out of a plain right shift.
  assign dbl = {req_valid, req_valid} >> ptr_q;
  assign rot = dbl[NREQ-1:0];

  // Lowest set bit of the rotated vector is the offset from ptr_q.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IDW'(i);
      end
    end
  end

  // Rotate back to an absolute index.
  assign win     = wrap_add(ptr_q, off);
  assign ptr_nxt = wrap_add(win, IDW'(1));

  // With no winner the mux still follows ptr_q; its output is then unused.
  assign sel = found ? win : ptr_q;

  always_comb begin
    sh_in  = '0;
    sh_amt = '0;
    sh_dir = SH_DIR_LEFT;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == sel) begin
        sh_in  = req_data[i*SH_DW +: SH_DW];
        sh_amt = req_shift[i*SH_SW +: SH_SW];
        sh_dir = req_dir[i];
      end
    end
  end

  barrel_shifter u_shifter (
    .data_in  (sh_in),
    .shift    (sh_amt),
    .dir      (sh_dir),
    .data_out (sh_out)
  );

  assign accept = rst_n && free && found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (IDW'(i) == win);
    end
  end

  // Next-state logic. An accept always leaves the register FULL, including
  // the drain-and-reload case; a drain without a new winner empties it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result and pointer registers only move on accept; after a drain the
  // stale result stays in place behind rsp_valid=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (accept) begin
      ptr_q    <= ptr_nxt;
      rsp_data <= sh_out;
      rsp_id   <= win;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign dbg_state = state_q;

endmodule
